// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter for NUM_IN valid/ready streams.
// A requester is chosen in an IDLE cycle and keeps the output until it
// delivers a beat with last set. The output beat is held in a single
// register, so a new beat is accepted whenever that register is empty
// or is being drained in the same cycle.
module stream_rr_arbiter #(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int GW         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_IN-1:0]            valid_in,
  input  logic [NUM_IN-1:0]            last_in,
  output logic [NUM_IN-1:0]            ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         last_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [GW-1:0]                grant_id,
  output logic                         busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [GW-1:0]         ptr;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         pick_hi;
  logic [GW-1:0]         pick_lo;
  logic                  found_hi;
  logic [GW-1:0]         next_ptr;
  logic                  any_valid;
  logic                  insert;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  assign any_valid = |valid_in;
  assign insert    = |(valid_in & ready_in);
  assign busy      = (state == LOCKED);
  assign next_ptr  = (grant_id == GW'(NUM_IN - 1)) ? '0 : grant_id + GW'(1);

  // Round-robin search: lowest valid index at or above ptr, else lowest overall.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves one unassigned and no latch is inferred.
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (valid_in[i]) begin
        pick_lo = GW'(i);
        if (GW'(i) >= ptr) begin
          pick_hi  = GW'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // Only the locked requester may be accepted, and only when the output
  // register is free or draining this cycle.
  always_comb begin
    ready_in = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ready_in[i] = (state == LOCKED) && (grant_id == GW'(i)) &&
                    (!valid_out || ready_out);
    end
  end

  // Select the granted requester's beat and end-of-packet flag.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = last_in[i];
      end
    end
  end

  // Arbitration FSM, round-robin pointer and the registered output beat.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      // NOTE: reset clears the output payload as well, not just valid, so a
      // stale beat from before reset can never be observed.
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state    <= LOCKED;
            grant_id <= pick;
          end
        end
        LOCKED: begin
          if (insert && sel_last) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase

      if (insert) begin
        valid_out <= 1'b1;
        data_out  <= sel_data;
        last_out  <= sel_last;
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a packet-level reference model
// and a beat scoreboard kept in this file.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   valid_in;
  logic [N-1:0]   last_in;
  logic [N-1:0]   ready_in;
  logic [W-1:0]   data_out;
  logic           last_out;
  logic           valid_out;
  logic           ready_out;
  logic [1:0]     grant_id;
  logic           busy;

  // Single-requester instance.
  logic           rst1;
  logic [W-1:0]   data1;
  logic [0:0]     valid1;
  logic [0:0]     last1;
  logic [0:0]     ready1;
  logic [W-1:0]   dout1;
  logic           lout1;
  logic           vout1;
  logic           rout1;
  logic [0:0]     gid1;
  logic           busy1;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .last_in(last_in), .ready_in(ready_in), .data_out(data_out),
    .last_out(last_out), .valid_out(valid_out), .ready_out(ready_out),
    .grant_id(grant_id), .busy(busy)
  );

  stream_rr_arbiter #(.NUM_IN(1), .DATA_WIDTH(W)) dut1 (
    .clk(clk), .rst(rst1), .data_in(data1), .valid_in(valid1),
    .last_in(last1), .ready_in(ready1), .data_out(dout1),
    .last_out(lout1), .valid_out(vout1), .ready_out(rout1),
    .grant_id(gid1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t sb[$];    // beats accepted but not yet delivered downstream
  beat_t seen[$];  // beats delivered downstream, for directed checks

  // Reference model: which requester owns the output (-1 = none), where the
  // next search starts, last granted index, and the held output beat.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_gid   = 0;
  logic         m_v     = 1'b0;
  logic [W-1:0] m_d     = '0;
  logic         m_l     = 1'b0;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_v     = 1'b0;
    m_d     = '0;
    m_l     = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: inputs are already driven; compare, advance the model,
  // and return just after the following falling edge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic         ins;
    beat_t        b;
    beat_t        e;
    int           idx;
    #1;
    exp_ready = '0;
    if (m_owner >= 0 && (!m_v || ready_out)) exp_ready[m_owner] = 1'b1;
    check("ready_in", ready_in, exp_ready);
    check("valid_out", valid_out, m_v);
    check("busy", busy, m_owner >= 0);
    check("grant_id", grant_id, m_gid);
    if (m_v) begin
      check("data_out", data_out, m_d);
      check("last_out", last_out, m_l);
    end
    if (rst && valid_out && ready_out) begin
      b.d = data_out;
      b.l = last_out;
      seen.push_back(b);
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_data", data_out, e.d);
        check("sb_last", last_out, e.l);
      end
    end
    if (!rst) begin
      model_reset();
    end else begin
      ins = (m_owner >= 0) && exp_ready[m_owner] && valid_in[m_owner];
      if (ins) begin
        m_v = 1'b1;
        m_d = data_in[m_owner*W +: W];
        m_l = last_in[m_owner];
        b.d = m_d;
        b.l = m_l;
        sb.push_back(b);
      end else if (m_v && ready_out) begin
        m_v = 1'b0;
      end
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (m_owner < 0 && valid_in[idx]) begin
            m_owner = idx;
            m_gid   = idx;
          end
        end
      end else if (ins && last_in[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    valid_in  = '0;
    last_in   = '0;
    ready_out = 1'b1;
    cycle();
    rst = 1'b1;
    seen.delete();
  endtask

  initial begin
    rst       = 1'b0;
    data_in   = '0;
    valid_in  = '0;
    last_in   = '0;
    ready_out = 1'b1;
    rst1      = 1'b0;
    data1     = '0;
    valid1    = '0;
    last1     = '0;
    rout1     = 1'b1;

    // Initial reset, applied before the model is consulted.
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_ready_in", ready_in, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    @(negedge clk);

    // Grant search from ptr=0 with requesters 1 and 3 valid.
    do_reset();
    valid_in = 4'b1010;
    cycle();
    check("r31_grant", grant_id, 1);
    data_in[15:8] = 8'h11;
    cycle();
    data_in[15:8] = 8'h12;
    last_in = 4'b0010;
    cycle();
    valid_in = 4'b1111;
    last_in  = 4'b0000;
    cycle();
    check("r31_ptr_next", grant_id, 2);
    check("r31_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("r31_beat0", {seen[0].d, seen[0].l}, {8'h11, 1'b0});
      check("r31_beat1", {seen[1].d, seen[1].l}, {8'h12, 1'b1});
    end

    // Everyone valid with single-beat packets: rotating grants, one idle gap.
    do_reset();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = 8'h30 + 8'(i);
    valid_in = 4'b1111;
    last_in  = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      cycle();
      check("r32_pulse", valid_out, c % 2);
      if (c % 2 == 1) check("r32_grant", grant_id, ((c - 1) / 2) % N);
    end
    check("r32_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      check("r32_data", seen[i].d, 8'h30 + 8'(i % N));
      check("r32_last", seen[i].l, 1);
    end

    // Three-beat packet with a two-cycle downstream stall on beat 2.
    do_reset();
    valid_in = 4'b0100;
    cycle();
    data_in[23:16] = 8'hA1;
    cycle();
    data_in[23:16] = 8'hA2;
    cycle();
    data_in[23:16] = 8'hA3;
    last_in   = 4'b0100;
    ready_out = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      check("r33_hold_valid", valid_out, 1);
      check("r33_hold_data", data_out, 8'hA2);
      check("r33_hold_last", last_out, 0);
      check("r33_ready2", ready_in[2], 0);
      cycle();
    end
    ready_out = 1'b1;
    cycle();
    valid_in = '0;
    last_in  = '0;
    cycle();
    cycle();
    check("r33_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check("r33_beat0", {seen[0].d, seen[0].l}, {8'hA1, 1'b0});
      check("r33_beat1", {seen[1].d, seen[1].l}, {8'hA2, 1'b0});
      check("r33_beat2", {seen[2].d, seen[2].l}, {8'hA3, 1'b1});
    end

    // Granted requester 0 pauses mid-packet while requester 3 waits.
    do_reset();
    valid_in = 4'b0001;
    data_in[7:0] = 8'h40;
    cycle();
    valid_in = 4'b1001;
    #1;
    check("r34_ready3", ready_in[3], 0);
    cycle();
    valid_in = 4'b1000;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("r34_ready3", ready_in[3], 0);
      check("r34_busy", busy, 1);
      cycle();
    end
    valid_in = 4'b1001;
    last_in  = 4'b0001;
    data_in[7:0] = 8'h41;
    cycle();
    check("r34_released", busy, 0);
    valid_in = 4'b1000;
    last_in  = 4'b0000;
    cycle();
    check("r34_next_grant", grant_id, 3);
    check("r34_next_busy", busy, 1);

    // Reset while a beat is held mid-packet; ptr returns to 0.
    do_reset();
    valid_in = 4'b0010;
    last_in  = 4'b0010;
    data_in[15:8] = 8'h51;
    cycle();
    cycle();
    valid_in = 4'b1000;
    last_in  = 4'b0000;
    data_in[31:24] = 8'h61;
    cycle();
    check("r35_grant3", grant_id, 3);
    cycle();
    check("r35_pre_valid", valid_out, 1);
    seen.delete();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    valid_in = 4'b0000;
    #1;
    check("r35_valid_out", valid_out, 0);
    check("r35_busy", busy, 0);
    check("r35_ready_in", ready_in, 0);
    check("r35_grant_rst", grant_id, 0);
    valid_in = 4'b1111;
    cycle();
    check("r35_restart_grant", grant_id, 0);
    check("r35_no_partial", seen.size(), 0);

    // Eight-beat packet streams with no bubble.
    do_reset();
    valid_in = 4'b0010;
    cycle();
    for (int k = 0; k < 8; k++) begin
      data_in[15:8] = 8'h70 + 8'(k);
      last_in = (k == 7) ? 4'b0010 : 4'b0000;
      cycle();
      check("r36_valid", valid_out, 1);
    end
    valid_in = '0;
    last_in  = '0;
    cycle();
    cycle();
    check("r36_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      check("r36_data", seen[i].d, 8'h70 + 8'(i));
      check("r36_last", seen[i].l, i == 7);
    end

    // Randomized traffic, including backpressure and occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      valid_in  = N'($urandom);
      last_in   = N'($urandom & $urandom);
      data_in   = $urandom;
      ready_out = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst = 1'b1;

    // Single-requester build: grant_id is always 0 and packets still flow.
    begin
      int n_beats;
      n_beats = 0;
      rst1 = 1'b1;
      for (int k = 0; k < 12; k++) begin
        valid1 = 1'b1;
        last1  = (k % 3 == 2);
        data1  = 8'(k);
        #1;
        check("n1_grant", gid1, 0);
        if (vout1 && rout1) n_beats++;
        @(posedge clk);
        @(negedge clk);
      end
      check("n1_beats_seen", n_beats > 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, SHALL set the number of requesting streams (legal 1..16).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the beat width.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low: rst=0 at a rising edge of clk SHALL reset the block.
REQ-005 data_in  input  NUM_IN*DATA_WIDTH  beat of requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 valid_in  input  NUM_IN  per-requester beat valid.
REQ-007 last_in  input  NUM_IN  per-requester end-of-packet flag, qualified by valid_in.
REQ-008 ready_in  output  NUM_IN  per-requester accept.
REQ-009 data_out  output  DATA_WIDTH  registered output beat.
REQ-010 last_out  output  1  registered end-of-packet flag.
REQ-011 valid_out  output  1  registered output valid.
REQ-012 ready_out  input  1  downstream accept.
REQ-013 grant_id  output  max(1,$clog2(NUM_IN))  index of the currently or last granted requester.
REQ-014 busy  output  1  high while a packet is locked.

Function
REQ-015 Insert on requester i = valid_in[i] & ready_in[i]; remove = valid_out & ready_out.
REQ-016 FSM states: IDLE and LOCKED; the reset state SHALL be IDLE.
REQ-017 In IDLE with any valid_in set, the block SHALL grant the first requester with valid_in set, searching upward from index ptr and wrapping modulo NUM_IN, and SHALL enter LOCKED next cycle with grant_id = that index.
REQ-018 In IDLE, ready_in SHALL be all zero, and no beat SHALL be accepted in the arbitration cycle.
REQ-019 In LOCKED, ready_in[grant_id] SHALL equal (!valid_out | ready_out); all other ready_in bits SHALL be 0.
REQ-020 On insert, data_in slice, last_in[grant_id] and valid=1 SHALL load the output register the same edge; latency input to valid_out SHALL be 1 cycle.
REQ-021 On remove without insert, valid_out SHALL clear; on simultaneous remove and insert, the register SHALL reload with no bubble.
REQ-022 valid_out, data_out and last_out SHALL hold stable while valid_out=1 and ready_out=0.
REQ-023 Insert of a beat with last_in=1 SHALL return the FSM to IDLE and set ptr = (grant_id+1) mod NUM_IN at the same edge.
REQ-024 The lock SHALL persist while the granted requester deasserts valid_in mid-packet; no other requester SHALL be served until its last beat.
REQ-025 A single-beat packet (last_in=1 on the first beat) SHALL occupy exactly one LOCKED cycle when ready.
REQ-026 Sustained throughput SHALL be one beat per cycle within a packet, with one IDLE arbitration cycle between packets.
REQ-027 With NUM_IN=1, grant_id SHALL be constant 0 and ptr SHALL stay 0.
REQ-028 busy SHALL equal (state == LOCKED).

Reset
REQ-029 On reset: state=IDLE, ptr=0, grant_id=0, valid_out=0, last_out=0, data_out=0, ready_in=0, busy=0.
REQ-030 Reset asserted mid-packet SHALL discard the held output beat and the lock, with no partial beat emitted afterwards.

Verification
REQ-031 NUM_IN=4, ptr=0, valid_in=4'b1010 in IDLE, ready_out=1 -> grant_id=1, beats of req1 appear on valid_out one cycle after acceptance, ptr=2 after last.
REQ-032 All four requesters continuously valid, single-beat packets -> grant order 0,1,2,3,0, each valid_out pulse separated by one idle cycle.
REQ-033 Req2 sends a 3-beat packet 0xA1,0xA2,0xA3, with ready_out=0 for 2 cycles on beat 2 -> data_out holds 0xA2, ready_in[2]=0 during the stall, output order is unchanged, and last_out=1 only on 0xA3.
REQ-034 Granted req0 drops valid_in for 3 cycles mid-packet while req3 is valid -> ready_in[3] stays 0 and busy stays 1 until req0's last beat.
REQ-035 rst=0 for one cycle while valid_out=1, mid-packet -> next cycle valid_out=0, busy=0, ready_in=0, and grant restarts from ptr=0.
REQ-036 ready_out=1 continuously, req1 streams 8 beats -> 8 consecutive valid_out cycles with no bubble.
